axi_burst_arbiter: RTL and testbench
====================================

Name: axi_burst_arbiter

Overview:
- Shares one axi_burst_master user port among NUM_REQ independent requesters (DMA engines, CSR-driven test generators).
- Round-robin arbitration at transaction granularity. Holds the grant for one complete burst, from start to write response or last read beat.
- Muxes the owner's request fields and write data into the master. Routes read beats, completion and status back to the owner only.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- LOCK_MAX, 4, maximum consecutive locked grants (used only with ARB_LOCK_EN).

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  level request, one bit per requester.
- req_w_r  in  NUM_REQ  0=write, 1=read.
- req_len  in  NUM_REQ*8  burst length minus one.
- req_addr  in  NUM_REQ*ADDR_W  start address.
- req_wdata  in  NUM_REQ*DATA_W  write data.
- req_wstrb  in  NUM_REQ*DATA_W/8  write strobes.
- req_stall_r  in  NUM_REQ  requester read back-pressure.
- req_lock  in  NUM_REQ  keep grant after completion (ARB_LOCK_EN only).
- gnt  out  NUM_REQ  one-hot owner indicator.
- done  out  NUM_REQ  one-cycle completion pulse.
- rsp_status  out  2  AXI response of the completed transaction, valid with done.
- rd_data  out  DATA_W  broadcast read data.
- rd_valid  out  NUM_REQ  read beat strobe, owner bit only.
- m_user_start  out  1  start pulse to master.
- m_user_w_r  out  1  latched owner direction.
- m_user_burst_len  out  8  latched owner length.
- m_user_addr  out  ADDR_W  latched owner address.
- m_user_data_in  out  DATA_W  owner write data, combinational mux.
- m_user_data_strb  out  DATA_W/8  owner write strobes, combinational mux.
- m_user_stall_r_data  out  1  owner req_stall_r; 0 when no read owner.
- m_user_free  in  1  master can accept start.
- m_user_data_out  in  DATA_W  master read data.
- m_user_data_out_valid  in  1  per-beat qualifier (read beat or write response).
- m_user_status  in  2  master response.

Behaviour:
- States: ARB, ISSUE, BUSY, DONE.
- Reset (async, immediate): state=ARB, rr pointer=0, beat count=0, latched fields=0, every output=0. Reset mid-burst abandons ownership; the master is reset on the same net.
- ARB: when any req_valid and m_user_free, select the first requesting index strictly after last_owner, wrapping modulo NUM_REQ. At the edge: latch w_r/len/addr, set gnt one-hot, go to ISSUE.
  - After reset, last_owner = NUM_REQ-1, so index 0 has first priority.
  - No request, or m_user_free=0: stay in ARB, gnt=0.
- ISSUE: m_user_start=1 for exactly one cycle, with latched fields on the bus. Then BUSY.
  - Latency: req_valid rising with master free gives m_user_start 1 cycle later (cycle N+1); gnt is high from N+1.
- BUSY, write: first m_user_data_out_valid ends the transaction.
- BUSY, read:
  - Each m_user_data_out_valid cycle: rd_data=m_user_data_out; rd_valid[owner]=1, same cycle (combinational).
  - An 8-bit beat counter increments per beat. The beat with counter==len is last.
- On the completing cycle: latch rsp_status from m_user_status; go to DONE.
- DONE: done[owner]=1 for one cycle with rsp_status; gnt stays high this cycle. last_owner=owner. Next state ARB.
  - Requester must drop req_valid in the done cycle or it re-requests. Rotation guarantees other waiting requesters are served first.
- Requester must hold its req fields stable from req_valid until gnt.
- Non-owner changes are ignored. req_valid deassertion after grant is ignored; the transaction completes.
- Simultaneous requests: strictly round-robin. No starvation; worst-case wait is NUM_REQ-1 transactions.
- len=0 read: one beat completes. len=255: counter reaches 255, no wrap.
- Stray m_user_data_out_valid in ARB/ISSUE/DONE is ignored (no rd_valid, no count).

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: in DONE, if req_lock[owner] and req_valid[owner] and consecutive-grant count < LOCK_MAX, the next state is ISSUE directly.
  - Same owner, new fields relatched, done still pulses, gnt never drops.
  - The consecutive count resets on any owner change. At LOCK_MAX, normal rotation applies.
- Undefined: req_lock port still exists but is ignored; behaviour is pure round-robin.

Decomposition:
- Shared package axi_burst_pkg: state encoding localparams, AXI response codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), direction constants.
- One sub-module rr_pick: combinational round-robin one-hot selector (inputs: request vector, last_owner; output: one-hot plus index), reusable by other arbiters.

Test Plan:
- Single write: req_valid[2], len=3, free=1 → m_user_start at +1 cycle with addr/len; data_out_valid with status=00 → done[2] next cycle, rsp_status=00, gnt cleared after.
- Read beats: req 1 read, len=7, 8 beats → rd_valid[1] exactly 8 times with matching rd_data; done[1] after beat 8; rd_valid[0,2,3] never set.
- Contention: all four request continuously from reset → grant order 0,1,2,3,0; each done precedes the next m_user_start.
- Master busy: free=0 for 10 cycles with req pending → no m_user_start, gnt=0; grant on the first free cycle.
- Reset during read (beat 3 of 8) → all outputs 0 immediately; next request starts fresh with counter 0.
- ARB_LOCK_EN, LOCK_MAX=2, req 0 locked, req 1 pending → grant order 0,0,1.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the burst arbiter family: FSM encoding,
// AXI response codes and transfer direction values.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    StArb   = 2'd0,
    StIssue = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic DirWrite = 1'b0;
  localparam logic DirRead  = 1'b1;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first requester strictly after
// last_owner (wrapping), returning it both one-hot and as an index.
module rr_pick
  import axi_burst_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    // Offsets start at 1 so the previous owner is considered last
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_owner) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid     = 1'b1;
        pick_idx       = cand_idx;
        pick[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_burst_arbiter.sv
// Round-robin arbiter sharing one axi_burst_master user port among NUM_REQ
// requesters, one whole burst per grant. Optional ARB_LOCK_EN adds bounded grant locking.
module axi_burst_arbiter
  import axi_burst_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_w_r,
  input  logic [NUM_REQ*8-1:0]      req_len,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
  input  logic [NUM_REQ-1:0]        req_stall_r,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [1:0]                rsp_status,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic                      m_user_start,
  output logic                      m_user_w_r,
  output logic [7:0]                m_user_burst_len,
  output logic [ADDR_W-1:0]         m_user_addr,
  output logic [DATA_W-1:0]         m_user_data_in,
  output logic [DATA_W/8-1:0]       m_user_data_strb,
  output logic                      m_user_stall_r_data,
  input  logic                      m_user_free,
  input  logic [DATA_W-1:0]         m_user_data_out,
  input  logic                      m_user_data_out_valid,
  input  logic [1:0]                m_user_status
);

  localparam int unsigned IDX_W  = idx_width(NUM_REQ);
  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               w_r_q, w_r_d;
  logic [7:0]         len_q, len_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         beat_q, beat_d;
  logic [1:0]         status_q, status_d;

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               start_arb;
  logic               complete;
  logic               relock;
  logic               load;
  logic [IDX_W-1:0]   load_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_owner (last_owner_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign start_arb = (state_q == StArb) && pick_valid && m_user_free;
  assign complete  = (state_q == StBusy) && m_user_data_out_valid &&
                     ((w_r_q == DirWrite) || (beat_q == len_q));

`ifdef ARB_LOCK_EN
  logic [7:0] lock_cnt_q, lock_cnt_d;

  assign relock = req_lock[owner_q] && req_valid[owner_q] && (32'(lock_cnt_q) < LOCK_MAX);

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (start_arb) begin
      lock_cnt_d = 8'd1;
    end else if ((state_q == StDone) && relock) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = (^req_lock) ^ (LOCK_MAX == 0);
  assign relock      = 1'b0;
`endif

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StArb:   if (start_arb) state_d = StIssue;
      StIssue: state_d = StBusy;
      StBusy:  if (complete) state_d = StDone;
      StDone:  state_d = relock ? StIssue : StArb;
      default: state_d = StArb;
    endcase
  end

  // Datapath next values: ownership, latched request fields, beat count, status
  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    w_r_d        = w_r_q;
    len_d        = len_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    status_d     = status_q;
    load         = 1'b0;
    load_idx     = owner_q;

    if (start_arb) begin
      load     = 1'b1;
      load_idx = pick_idx;
      gnt_d    = pick;
    end
    if ((state_q == StBusy) && m_user_data_out_valid && (w_r_q == DirRead) &&
        (beat_q != len_q)) begin
      beat_d = beat_q + 8'd1;
    end
    if (complete) begin
      status_d = m_user_status;
    end
    if (state_q == StDone) begin
      last_owner_d = owner_q;
      if (relock) begin
        load = 1'b1;
      end else begin
        gnt_d = '0;
      end
    end
    if (load) begin
      owner_d = load_idx;
      w_r_d   = req_w_r[load_idx];
      len_d   = req_len[8*load_idx +: 8];
      addr_d  = req_addr[ADDR_W*load_idx +: ADDR_W];
      beat_d  = '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      w_r_q        <= 1'b0;
      len_q        <= '0;
      addr_q       <= '0;
      beat_q       <= '0;
      status_q     <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      w_r_q        <= w_r_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      status_q     <= status_d;
    end
  end

  // Outputs
  always_comb begin
    done                = '0;
    rd_valid            = '0;
    rd_data             = '0;
    m_user_start        = 1'b0;
    m_user_data_in      = '0;
    m_user_data_strb    = '0;
    m_user_stall_r_data = 1'b0;
    case (state_q)
      StIssue: m_user_start = 1'b1;
      StBusy: begin
        if ((w_r_q == DirRead) && m_user_data_out_valid) begin
          rd_valid = gnt_q;
          rd_data  = m_user_data_out;
        end
      end
      StDone:  done = gnt_q;
      default: ;
    endcase
    if (state_q != StArb) begin
      m_user_data_in      = req_wdata[DATA_W*owner_q +: DATA_W];
      m_user_data_strb    = req_wstrb[STRB_W*owner_q +: STRB_W];
      m_user_stall_r_data = (w_r_q == DirRead) && req_stall_r[owner_q];
    end
  end

  assign gnt              = gnt_q;
  assign rsp_status       = status_q;
  assign m_user_w_r       = w_r_q;
  assign m_user_burst_len = len_q;
  assign m_user_addr      = addr_q;

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Directed self-checking bench for axi_burst_arbiter (4 requesters, LOCK_MAX=2).
module tb_axi_burst_arbiter;

  logic          aclk;
  logic          areset;
  logic [3:0]    req_valid;
  logic [3:0]    req_w_r;
  logic [31:0]   req_len;
  logic [127:0]  req_addr;
  logic [255:0]  req_wdata;
  logic [31:0]   req_wstrb;
  logic [3:0]    req_stall_r;
  logic [3:0]    req_lock;
  logic [3:0]    gnt;
  logic [3:0]    done;
  logic [1:0]    rsp_status;
  logic [63:0]   rd_data;
  logic [3:0]    rd_valid;
  logic          m_user_start;
  logic          m_user_w_r;
  logic [7:0]    m_user_burst_len;
  logic [31:0]   m_user_addr;
  logic [63:0]   m_user_data_in;
  logic [7:0]    m_user_data_strb;
  logic          m_user_stall_r_data;
  logic          m_user_free;
  logic [63:0]   m_user_data_out;
  logic          m_user_data_out_valid;
  logic [1:0]    m_user_status;

  int n_checks = 0;
  int n_pass   = 0;
  int order_q[8];
  int ng;
  int bad_seq;

  axi_burst_arbiter #(
    .NUM_REQ  (4),
    .ADDR_W   (32),
    .DATA_W   (64),
    .LOCK_MAX (2)
  ) dut (
    .aclk                  (aclk),
    .areset                (areset),
    .req_valid             (req_valid),
    .req_w_r               (req_w_r),
    .req_len               (req_len),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .req_wstrb             (req_wstrb),
    .req_stall_r           (req_stall_r),
    .req_lock              (req_lock),
    .gnt                   (gnt),
    .done                  (done),
    .rsp_status            (rsp_status),
    .rd_data               (rd_data),
    .rd_valid              (rd_valid),
    .m_user_start          (m_user_start),
    .m_user_w_r            (m_user_w_r),
    .m_user_burst_len      (m_user_burst_len),
    .m_user_addr           (m_user_addr),
    .m_user_data_in        (m_user_data_in),
    .m_user_data_strb      (m_user_data_strb),
    .m_user_stall_r_data   (m_user_stall_r_data),
    .m_user_free           (m_user_free),
    .m_user_data_out       (m_user_data_out),
    .m_user_data_out_valid (m_user_data_out_valid),
    .m_user_status         (m_user_status)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [7:0] len,
                         input logic [31:0] addr);
    req_w_r[i]             = wr;
    req_len[8*i +: 8]      = len;
    req_addr[32*i +: 32]   = addr;
    req_wdata[64*i +: 64]  = {32'hDA7A_0000 + 32'(i), addr};
    req_wstrb[8*i +: 8]    = 8'hA0 + 8'(i);
    req_valid[i]           = 1'b1;
  endtask

  task automatic do_reset();
    areset                = 1'b1;
    req_valid             = '0;
    req_w_r               = '0;
    req_len               = '0;
    req_addr              = '0;
    req_wdata             = '0;
    req_wstrb             = '0;
    req_stall_r           = '0;
    req_lock              = '0;
    m_user_free           = 1'b1;
    m_user_data_out       = '0;
    m_user_data_out_valid = 1'b0;
    m_user_status         = 2'b00;
    step();
    step();
    areset = 1'b0;
  endtask

  // Serves each issued write with one response a cycle later; records grant order.
  task automatic run_grants(input int want);
    int phase;
    bit seen_done;
    ng        = 0;
    bad_seq   = 0;
    phase     = 0;
    seen_done = 1'b1;
    for (int c = 0; c < 300 && ng < want; c++) begin
      step();
      m_user_data_out_valid = 1'b0;
      #1;
      if (done != 4'b0000) seen_done = 1'b1;
      if (m_user_start) begin
        if (!seen_done) bad_seq++;
        order_q[ng] = oh_idx(gnt);
        ng++;
        seen_done = 1'b0;
        phase     = 1;
      end else if (phase == 1) begin
        m_user_data_out_valid = 1'b1;
        phase = 0;
      end
    end
    m_user_data_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || rd_valid !== 4'b0 || m_user_start !== 1'b0)
      $display("FAIL reset_ctrl gnt=%b done=%b rd_valid=%b start=%b want all 0",
               gnt, done, rd_valid, m_user_start);
    else n_pass++;
    n_checks++;
    if (m_user_addr !== 32'h0 || m_user_burst_len !== 8'h0 || rsp_status !== 2'b00 ||
        m_user_stall_r_data !== 1'b0 || rd_data !== 64'h0)
      $display("FAIL reset_data addr=%h len=%h status=%b stall=%b rd_data=%h want 0",
               m_user_addr, m_user_burst_len, rsp_status, m_user_stall_r_data, rd_data);
    else n_pass++;
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(2, 1'b0, 8'd3, 32'h1000_2000);
    #1;
    n_checks++;
    if (m_user_start !== 1'b0 || gnt !== 4'b0)
      $display("FAIL write_pregrant start=%b gnt=%b want 0/0000", m_user_start, gnt);
    else n_pass++;
    step();
    n_checks++;
    if (m_user_start !== 1'b1 || gnt !== 4'b0100)
      $display("FAIL write_start start=%b gnt=%b want 1/0100", m_user_start, gnt);
    else n_pass++;
    n_checks++;
    if (m_user_addr !== 32'h1000_2000 || m_user_burst_len !== 8'd3 || m_user_w_r !== 1'b0)
      $display("FAIL write_fields addr=%h len=%0d w_r=%b want 10002000/3/0",
               m_user_addr, m_user_burst_len, m_user_w_r);
    else n_pass++;
    n_checks++;
    if (m_user_data_in !== 64'hDA7A_0002_1000_2000 || m_user_data_strb !== 8'hA2)
      $display("FAIL write_data data=%h strb=%h want da7a000210002000/a2",
               m_user_data_in, m_user_data_strb);
    else n_pass++;
    req_valid = '0;
    step();
    n_checks++;
    if (m_user_start !== 1'b0 || gnt !== 4'b0100)
      $display("FAIL write_busy start=%b gnt=%b want 0/0100", m_user_start, gnt);
    else n_pass++;
    step();
    m_user_data_out_valid = 1'b1;
    m_user_status         = 2'b00;
    step();
    m_user_data_out_valid = 1'b0;
    m_user_status         = 2'b11;
    n_checks++;
    if (done !== 4'b0100 || rsp_status !== 2'b00 || gnt !== 4'b0100)
      $display("FAIL write_done done=%b status=%b gnt=%b want 0100/00/0100",
               done, rsp_status, gnt);
    else n_pass++;
    step();
    n_checks++;
    if (done !== 4'b0 || gnt !== 4'b0)
      $display("FAIL write_after done=%b gnt=%b want 0000/0000", done, gnt);
    else n_pass++;
  endtask

  task automatic test_read_beats();
    int nvalid;
    int foreign;
    logic [63:0] exp_d;
    nvalid  = 0;
    foreign = 0;
    do_reset();
    set_req(1, 1'b1, 8'd7, 32'h0000_4000);
    step();
    n_checks++;
    if (m_user_w_r !== 1'b1 || m_user_burst_len !== 8'd7 || gnt !== 4'b0010)
      $display("FAIL read_start w_r=%b len=%0d gnt=%b want 1/7/0010",
               m_user_w_r, m_user_burst_len, gnt);
    else n_pass++;
    req_valid   = '0;
    req_stall_r = 4'b0010;
    step();
    n_checks++;
    if (m_user_stall_r_data !== 1'b1)
      $display("FAIL read_stall got %b want 1", m_user_stall_r_data);
    else n_pass++;
    req_stall_r = 4'b0000;
    for (int b = 0; b < 8; b++) begin
      exp_d                 = 64'hFEED_0000_0000_0000 + 64'(b);
      m_user_data_out_valid = 1'b1;
      m_user_data_out       = exp_d;
      m_user_status         = (b == 7) ? 2'b10 : 2'b00;
      #1;
      if (rd_valid == 4'b0010) nvalid++;
      if ((rd_valid & 4'b1101) != 4'b0) foreign++;
      n_checks++;
      if (rd_valid !== 4'b0010 || rd_data !== exp_d)
        $display("FAIL read_beat%0d rd_valid=%b rd_data=%h want 0010/%h",
                 b, rd_valid, rd_data, exp_d);
      else n_pass++;
      if (b < 7 && done !== 4'b0)
        $display("FAIL read_early_done beat%0d done=%b want 0000", b, done);
      step();
    end
    m_user_data_out = 64'h1234_5678_9ABC_DEF0;
    #1;
    n_checks++;
    if (done !== 4'b0010 || rsp_status !== 2'b10)
      $display("FAIL read_done done=%b status=%b want 0010/10", done, rsp_status);
    else n_pass++;
    n_checks++;
    if (rd_valid !== 4'b0)
      $display("FAIL stray_in_done rd_valid=%b want 0000", rd_valid);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (rd_valid !== 4'b0 || gnt !== 4'b0 || done !== 4'b0)
      $display("FAIL stray_in_arb rd_valid=%b gnt=%b done=%b want 0", rd_valid, gnt, done);
    else n_pass++;
    m_user_data_out_valid = 1'b0;
    n_checks++;
    if (nvalid !== 8 || foreign !== 0)
      $display("FAIL read_count beats=%0d foreign=%0d want 8/0", nvalid, foreign);
    else n_pass++;
  endtask

  task automatic test_len_zero();
    do_reset();
    set_req(3, 1'b1, 8'd0, 32'h0000_8000);
    step();
    req_valid = '0;
    step();
    m_user_data_out_valid = 1'b1;
    m_user_data_out       = 64'h0BAD_F00D_0000_0001;
    #1;
    n_checks++;
    if (rd_valid !== 4'b1000)
      $display("FAIL len0_beat rd_valid=%b want 1000", rd_valid);
    else n_pass++;
    step();
    m_user_data_out_valid = 1'b0;
    n_checks++;
    if (done !== 4'b1000)
      $display("FAIL len0_done done=%b want 1000", done);
    else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'd0, 32'h100 * i);
    run_grants(5);
    n_checks++;
    if (ng !== 5)
      $display("FAIL contention_timeout grants=%0d want 5", ng);
    else n_pass++;
    n_checks++;
    if (ng != 5 || order_q[0] !== 0 || order_q[1] !== 1 || order_q[2] !== 2 ||
        order_q[3] !== 3 || order_q[4] !== 0)
      $display("FAIL contention_order got %0d,%0d,%0d,%0d,%0d want 0,1,2,3,0",
               order_q[0], order_q[1], order_q[2], order_q[3], order_q[4]);
    else n_pass++;
    n_checks++;
    if (bad_seq !== 0)
      $display("FAIL contention_done_first got %0d starts without done want 0", bad_seq);
    else n_pass++;
  endtask

  task automatic test_master_busy();
    int bad;
    bad = 0;
    do_reset();
    m_user_free = 1'b0;
    set_req(3, 1'b0, 8'd1, 32'h0000_C000);
    for (int c = 0; c < 10; c++) begin
      step();
      if (m_user_start !== 1'b0 || gnt !== 4'b0) bad++;
    end
    n_checks++;
    if (bad !== 0)
      $display("FAIL busy_hold got %0d cycles with start/gnt want 0", bad);
    else n_pass++;
    m_user_free = 1'b1;
    step();
    n_checks++;
    if (m_user_start !== 1'b1 || gnt !== 4'b1000)
      $display("FAIL busy_release start=%b gnt=%b want 1/1000", m_user_start, gnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_req(0, 1'b1, 8'd7, 32'h0000_A000);
    req_stall_r = 4'b0001;
    step();
    req_valid = '0;
    step();
    for (int b = 0; b < 3; b++) begin
      m_user_data_out_valid = 1'b1;
      m_user_data_out       = 64'h77 + 64'(b);
      step();
    end
    #2;
    areset = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b0 || rd_valid !== 4'b0 || rd_data !== 64'h0 || m_user_stall_r_data !== 1'b0)
      $display("FAIL midrst_ctrl gnt=%b rd_valid=%b rd_data=%h stall=%b want 0",
               gnt, rd_valid, rd_data, m_user_stall_r_data);
    else n_pass++;
    n_checks++;
    if (m_user_addr !== 32'h0 || m_user_burst_len !== 8'h0 || m_user_w_r !== 1'b0)
      $display("FAIL midrst_fields addr=%h len=%h w_r=%b want 0", m_user_addr,
               m_user_burst_len, m_user_w_r);
    else n_pass++;
    m_user_data_out_valid = 1'b0;
    req_stall_r           = '0;
    step();
    areset = 1'b0;
    set_req(2, 1'b1, 8'd1, 32'h0000_B000);
    step();
    n_checks++;
    if (gnt !== 4'b0100 || m_user_start !== 1'b1)
      $display("FAIL midrst_regrant gnt=%b start=%b want 0100/1", gnt, m_user_start);
    else n_pass++;
    req_valid = '0;
    step();
    m_user_data_out_valid = 1'b1;
    step();
    n_checks++;
    if (done !== 4'b0)
      $display("FAIL midrst_beat1 done=%b want 0000", done);
    else n_pass++;
    step();
    m_user_data_out_valid = 1'b0;
    n_checks++;
    if (done !== 4'b0100)
      $display("FAIL midrst_beat2 done=%b want 0100", done);
    else n_pass++;
  endtask

  task automatic test_lock();
    int exp_o[3];
`ifdef ARB_LOCK_EN
    exp_o = '{0, 0, 1};
`else
    exp_o = '{0, 1, 0};
`endif
    do_reset();
    set_req(0, 1'b0, 8'd0, 32'h0000_0010);
    set_req(1, 1'b0, 8'd0, 32'h0000_0020);
    req_lock = 4'b0001;
    run_grants(3);
    n_checks++;
    if (ng !== 3 || order_q[0] !== exp_o[0] || order_q[1] !== exp_o[1] ||
        order_q[2] !== exp_o[2])
      $display("FAIL lock_order grants=%0d got %0d,%0d,%0d want %0d,%0d,%0d", ng,
               order_q[0], order_q[1], order_q[2], exp_o[0], exp_o[1], exp_o[2]);
    else n_pass++;
    n_checks++;
    if (bad_seq !== 0)
      $display("FAIL lock_done_first got %0d starts without done want 0", bad_seq);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) order_q[i] = -1;
    test_reset();
    test_single_write();
    test_read_beats();
    test_len_zero();
    test_contention();
    test_master_busy();
    test_reset_mid_read();
    test_lock();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
